key_onehot_scanner: RTL and testbench
=====================================

Name: key_onehot_scanner

Overview:
- Upstream stage of the 4-to-2 encoder. Takes four raw, asynchronous key/button lines and produces a clean one-hot 4-bit code plus a valid flag and a press strobe.
- The one-hot output drives the encoder's 4-bit input directly.
- Synchronises and debounces each line, then resolves simultaneous presses by priority.
- Locks onto one key until that key is released, so the downstream code never glitches.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a key must differ from its stable state before the stable state flips. Legal range ≥1. Counter width is derived internally as clog2(DEBOUNCE_CYCLES+1).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- key_in  input  4  raw key lines, 1 = pressed, asynchronous to clk
- onehot  output  4  registered one-hot code of the captured key; 4'b0000 when none is held
- valid  output  1  registered; 1 while onehot is non-zero
- press  output  1  registered single-cycle strobe on each new capture

Behaviour:
- Clock and reset: one clock (clk). Reset rst is asynchronous and active-high. All flops clear immediately on rst=1, independent of clk.
- Reset values:
  - onehot=4'b0000, valid=0, press=0.
  - Synchroniser flops = 0, stable states = 0, debounce counters = 0, FSM = IDLE.
- Synchroniser: two flops per bit. sync[i] = key_in[i] delayed by 2 edges.
- Debounce, per bit i:
  - If sync[i]==stable[i], cnt[i] clears to 0.
  - Otherwise cnt[i] increments.
  - When cnt[i]==DEBOUNCE_CYCLES-1 and a mismatch persists, stable[i] toggles and cnt[i] clears on that edge.
  - Any single-cycle return to match restarts the count from 0 (glitch rejection).
- FSM, two states:
  - IDLE:
    - If stable!=0, capture the highest-index set bit of stable. Bit 3 has highest priority, bit 0 lowest.
    - Load onehot with only that bit, set valid=1, pulse press=1 for one cycle, go to HELD.
    - Otherwise onehot=0, valid=0.
  - HELD:
    - onehot holds the captured bit and press=0.
    - Other keys pressing or releasing have no effect, including higher-priority keys.
    - When stable[captured]==0: onehot=0, valid=0, return to IDLE on that edge.
  - Immediately after returning to IDLE, if other keys are still stable-pressed, the next capture occurs on the following edge. There is always ≥1 cycle with onehot=0 between captures, and press pulses again.
- Latency: key_in asserted and held before edge E → sync at E+2 → stable flips at E+1+DEBOUNCE_CYCLES+1 → onehot/valid/press at E+DEBOUNCE_CYCLES+3. Default: 7 edges. Release latency is identical.
- Invariants:
  - onehot is always 4'b0000 or exactly one bit set.
  - valid == |onehot.
  - press is never high for two consecutive cycles.
  - press is high only in the cycle in which valid rises or the captured key changes after a zero gap.
- Simultaneous events: several keys stabilising on the same edge → highest index wins.
- Reset mid-operation: an rst pulse while in HELD clears outputs asynchronously. After rst deasserts, a still-pressed key is re-debounced from scratch, with full latency, then captured with a new press strobe.

Test Plan:
- Reset/idle: rst=1 for 3 cycles, key_in=0 → onehot=0000, valid=0, press=0. Apply rst asynchronously mid-cycle → outputs clear before the next clk edge.
- Single press: key_in=0100 held → onehot=0100, valid=1, press=1 exactly 7 edges after the change (DEBOUNCE_CYCLES=4). press=0 on the next cycle. Release → onehot=0000 7 edges after release.
- Glitch rejection: key_in[1] pulsed high for 3 cycles, then 0, repeated twice → onehot stays 0000 and press never asserts.
- Priority: key_in 0000→1010 in one cycle → onehot=1000, single press. Release bit 3 only → onehot=0000 for exactly 1 cycle, then 0010 with a second press.
- Lock: hold key 0 until captured (onehot=0001), then press key 3 → onehot stays 0001 with no press. Release key 0 → gap cycle, then onehot=1000 with press.
- Reset while held: onehot=0100, assert rst 2 cycles with key still pressed → outputs 0 during rst. Recapture of 0100 occurs 7 edges after rst deasserts, with press=1.

Source files
------------

// File: rtl/key_onehot_scanner_if.sv
// ---------------------------------------------------------------------------
// key_onehot_scanner_if
//   Groups the key inputs and the captured-key outputs of the scanner.
//   Signals:
//     key_in [3:0]  raw key lines, 1 = pressed, asynchronous to clk
//     onehot [3:0]  one-hot code of the captured key, 4'b0000 when none held
//     valid         high while onehot is non-zero
//     press         single-cycle strobe on each new capture
//   Modports:
//     master  drives key_in and observes the outputs (key source / bench)
//     slave   the scanner itself
// ---------------------------------------------------------------------------
interface key_onehot_scanner_if;
    logic [3:0] key_in;
    logic [3:0] onehot;
    logic       valid;
    logic       press;

    modport master (output key_in, input onehot, input valid, input press);
    modport slave  (input key_in, output onehot, output valid, output press);
endinterface

// File: rtl/key_onehot_scanner.sv
// ---------------------------------------------------------------------------
// key_onehot_scanner
//   Front end of the 4-to-2 encoder. Each raw key line is synchronised
//   through two flops and debounced. A two-state FSM then captures the
//   highest-index pressed key and locks onto it until that key is released,
//   so the one-hot code handed to the encoder never glitches.
//   Ports:
//     clk  rising-edge system clock
//     rst  asynchronous, active-high reset
//     bus  key_onehot_scanner_if.slave (key_in in; onehot, valid, press out)
//   Parameter:
//     DEBOUNCE_CYCLES  consecutive mismatching synchronised samples needed
//                      before a key's stable state flips (>= 1)
// ---------------------------------------------------------------------------
module key_onehot_scanner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    key_onehot_scanner_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HELD
    } state_t;

    logic [3:0]       r_meta;
    logic [3:0]       r_sync;
    logic [3:0]       r_stable;
    logic [CNT_W-1:0] r_cnt [4];

    state_t           r_state;
    state_t           w_stateNext;
    logic [1:0]       r_capIdx;
    logic [1:0]       w_capIdxNext;
    logic [1:0]       w_priIdx;

    logic [3:0]       r_onehot;
    logic             r_valid;
    logic             r_press;
    logic [3:0]       w_onehotNext;
    logic             w_pressNext;

    // Two-flop synchroniser for the asynchronous key lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= bus.key_in;
            r_sync <= r_meta;
        end
    end

    // Per-key debounce: the count only survives an unbroken run of
    // mismatches, so any single-cycle return to the stable level restarts it.
    // The flip happens on the edge that would otherwise take the count to
    // DEBOUNCE_CYCLES.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stable <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (r_sync[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_stable[i] <= ~r_stable[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Priority pick among stable-pressed keys: later iterations overwrite
    // earlier ones, so the highest index wins.
    always_comb begin
        w_priIdx = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_stable[i]) begin
                w_priIdx = 2'(i);
            end
        end
    end

    // FSM state register, together with the index of the locked key.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_capIdx <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_capIdx <= w_capIdxNext;
        end
    end

    // Next-state logic. Once HELD, only the captured key's release matters;
    // every other key, including higher-priority ones, is ignored.
    always_comb begin
        w_stateNext  = r_state;
        w_capIdxNext = r_capIdx;
        case (r_state)
            IDLE: begin
                if (|r_stable) begin
                    w_stateNext  = HELD;
                    w_capIdxNext = w_priIdx;
                end
            end
            HELD: begin
                if (!r_stable[r_capIdx]) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Output decode, registered below. The release edge drives onehot to
    // zero and moves to IDLE, so there is always at least one zero cycle
    // before the next capture and its press strobe.
    always_comb begin
        w_onehotNext = '0;
        w_pressNext  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|r_stable) begin
                    w_onehotNext = 4'b0001 << w_priIdx;
                    w_pressNext  = 1'b1;
                end
            end
            HELD: begin
                if (r_stable[r_capIdx]) begin
                    w_onehotNext = 4'b0001 << r_capIdx;
                end
            end
            default: begin
                w_onehotNext = '0;
            end
        endcase
    end

    // Output registers; valid is derived from the same next value so it
    // always equals the OR of onehot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_onehot <= '0;
            r_valid  <= 1'b0;
            r_press  <= 1'b0;
        end else begin
            r_onehot <= w_onehotNext;
            r_valid  <= |w_onehotNext;
            r_press  <= w_pressNext;
        end
    end

    assign bus.onehot = r_onehot;
    assign bus.valid  = r_valid;
    assign bus.press  = r_press;

endmodule

// File: tb/tb_key_onehot_scanner.sv
// ---------------------------------------------------------------------------
// tb_key_onehot_scanner
//   Bench for key_onehot_scanner with DEBOUNCE_CYCLES = 4 (7-edge latency).
//   Each stimulus change pushes the output events it must cause (cycle,
//   onehot, press) onto a queue; a monitor pops and compares them whenever
//   onehot changes, and checks press is low on every other cycle.
// ---------------------------------------------------------------------------
module tb_key_onehot_scanner;

    localparam int LAT = 7;

    typedef struct {
        logic [3:0] key;
        int         hold;
        logic [3:0] expCap;
    } vec_t;

    typedef struct {
        int         cyc;
        logic [3:0] onehot;
        logic       press;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    exp_t       expQ[$];
    vec_t       vecs[7];

    key_onehot_scanner_if bus();

    key_onehot_scanner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10-time-unit clock.
    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected and observed events.
    always @(posedge clk) cyc <= cyc + 1;

    // Drive the key lines; called just after a rising edge.
    task automatic applyStimulus(input logic [3:0] key);
        bus.key_in = key;
    endtask

    // Direct comparison of all three outputs.
    task automatic checkOutput(input string name, input logic [3:0] eOnehot,
                               input logic eValid, input logic ePress);
        total++;
        if (bus.onehot !== eOnehot || bus.valid !== eValid || bus.press !== ePress) begin
            bad++;
            $display("[TB] FAIL %s: got onehot=%b valid=%b press=%b, required onehot=%b valid=%b press=%b",
                     name, bus.onehot, bus.valid, bus.press, eOnehot, eValid, ePress);
        end
    endtask

    task automatic pushExp(input int c, input logic [3:0] o, input logic p);
        exp_t e;
        e.cyc    = c;
        e.onehot = o;
        e.press  = p;
        expQ.push_back(e);
    endtask

    // Scoreboard monitor: samples on the falling edge.
    task automatic monitorLoop();
        logic [3:0] prevOnehot;
        exp_t       e;
        prevOnehot = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevOnehot = '0;
            end else begin
                total++;
                if (bus.valid !== (|bus.onehot) || !$onehot0(bus.onehot)) begin
                    bad++;
                    $display("[TB] FAIL invariant cyc=%0d: got onehot=%b valid=%b, required one-hot-or-zero with valid=|onehot",
                             cyc, bus.onehot, bus.valid);
                end
                total++;
                if (bus.onehot !== prevOnehot) begin
                    if (expQ.size() == 0) begin
                        bad++;
                        $display("[TB] FAIL unexpectedChange cyc=%0d: got onehot=%b press=%b, required onehot=%b",
                                 cyc, bus.onehot, bus.press, prevOnehot);
                    end else begin
                        e = expQ.pop_front();
                        if (e.cyc != cyc || e.onehot !== bus.onehot || e.press !== bus.press) begin
                            bad++;
                            $display("[TB] FAIL event: got cyc=%0d onehot=%b press=%b, required cyc=%0d onehot=%b press=%b",
                                     cyc, bus.onehot, bus.press, e.cyc, e.onehot, e.press);
                        end
                    end
                    prevOnehot = bus.onehot;
                end else if (bus.press !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL strayPress cyc=%0d: got press=%b, required press=0", cyc, bus.press);
                end
            end
        end
    endtask

    // Bounded wait for all expected events, then a quiet period so any
    // unexpected late change is still seen by the monitor.
    task automatic waitDrain(input string name);
        int k;
        k = 0;
        while (expQ.size() != 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        total++;
        if (expQ.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain %s: got %0d pending events, required 0", name, expQ.size());
            expQ.delete();
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int m;

        // key, cycles held, expected captured code (0 = must be rejected)
        vecs[0] = '{4'b0100, 10, 4'b0100};
        vecs[1] = '{4'b0010,  3, 4'b0000};
        vecs[2] = '{4'b1010, 10, 4'b1000};
        vecs[3] = '{4'b0111, 10, 4'b0100};
        vecs[4] = '{4'b1111,  5, 4'b1000};
        vecs[5] = '{4'b0001,  4, 4'b0001};
        vecs[6] = '{4'b0010,  2, 4'b0000};

        bus.key_in = '0;
        rst = 1'b1;
        fork
            monitorLoop();
        join_none

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetIdle", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;

        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].key);
            if (vecs[v].expCap != 4'b0000) pushExp(cyc + LAT, vecs[v].expCap, 1'b1);
            repeat (vecs[v].hold) @(posedge clk);
            #1;
            applyStimulus(4'b0000);
            if (vecs[v].expCap != 4'b0000) pushExp(cyc + LAT, 4'b0000, 1'b0);
            waitDrain($sformatf("vec%0d", v));
        end

        // Glitch burst: two 3-cycle pulses split by a single low cycle.
        applyStimulus(4'b0010);
        repeat (3) @(posedge clk); #1;
        applyStimulus(4'b0000);
        @(posedge clk); #1;
        applyStimulus(4'b0010);
        repeat (3) @(posedge clk); #1;
        applyStimulus(4'b0000);
        waitDrain("glitch");

        // Priority then release of the winner only: one zero cycle, recapture.
        applyStimulus(4'b1010);
        pushExp(cyc + LAT, 4'b1000, 1'b1);
        repeat (12) @(posedge clk); #1;
        applyStimulus(4'b0010);
        pushExp(cyc + LAT, 4'b0000, 1'b0);
        pushExp(cyc + LAT + 1, 4'b0010, 1'b1);
        repeat (12) @(posedge clk); #1;
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 1'b0);
        waitDrain("priority");

        // Lock: a higher-priority key arriving while held is ignored.
        applyStimulus(4'b0001);
        pushExp(cyc + LAT, 4'b0001, 1'b1);
        repeat (10) @(posedge clk); #1;
        applyStimulus(4'b1001);
        repeat (10) @(posedge clk); #1;
        checkOutput("lockHeld", 4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b1000);
        pushExp(cyc + LAT, 4'b0000, 1'b0);
        pushExp(cyc + LAT + 1, 4'b1000, 1'b1);
        repeat (12) @(posedge clk); #1;
        applyStimulus(4'b0000);
        pushExp(cyc + LAT, 4'b0000, 1'b0);
        waitDrain("lock");

        // Reset while held: asynchronous clear, then full-latency recapture.
        applyStimulus(4'b0100);
        pushExp(cyc + LAT, 4'b0100, 1'b1);
        waitDrain("preReset");
        checkOutput("heldBeforeRst", 4'b0100, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncRstClear", 4'b0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk); #1;
        checkOutput("duringRst", 4'b0000, 1'b0, 1'b0);
        rst = 1'b0;
        n = cyc;
        pushExp(n + LAT, 4'b0100, 1'b1);
        repeat (LAT - 1) @(posedge clk); #1;
        checkOutput("beforeRecapture", 4'b0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        checkOutput("recapture", 4'b0100, 1'b1, 1'b1);
        @(posedge clk); #1;
        checkOutput("recapturePressDrop", 4'b0100, 1'b1, 1'b0);
        m = cyc;
        applyStimulus(4'b0000);
        pushExp(m + LAT, 4'b0000, 1'b0);
        waitDrain("postReset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
